rx_top: RTL and testbench
=========================

# rx_top

Multi-byte UART receive front end: the receive-side counterpart of the word transmitter. When armed, it collects 0–4 serial bytes from `RxD` and assembles them LSB-byte-first into one 32-bit word. It then presents that word with a one-cycle valid strobe to the measurement/control logic. Bit-level reception is done by a `receiver` sub-module; `rx_top` owns byte counting, word assembly, error handling and inter-byte timeout.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud); must be ≥ 4.
- `TIMEOUT_CLKS`, default 86800: maximum idle clocks allowed between bytes while collecting; 0 disables the timeout.
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RxD`  in  1  serial line, idle high, asynchronous to `clk`.
- `start`  in  1  arm request, sampled only in Idle.
- `bytes`  in  3  bytes to collect, latched with `start`; values 5–7 clamp to 4.
- `busy`  out  1  high whenever state ≠ Idle.
- `word`  out  32  assembled word, held until the next successful delivery.
- `valid`  out  1  one-cycle strobe: `word` updated.
- `frame_err`  out  1  one-cycle strobe: bad stop bit, collection aborted.
- `timeout`  out  1  one-cycle strobe: inter-byte gap exceeded, collection aborted.

## Operation
- **Reset values:** all outputs 0, `word` = 0, state Idle.
- **receiver:**
  - `RxD` passes through a 2-flop synchronizer.
  - A falling edge in line-idle starts a frame. The start bit is re-checked at `CLKS_PER_BIT/2`; if it is high, the frame is a false start and the receiver returns to idle silently.
  - 8 data bits are sampled LSB-first, each at mid-bit.
  - The stop bit is sampled at mid-bit. Low gives `rx_err`; high gives `rx_valid`. Both are one-cycle strobes carrying `rx_byte`.
- **rx_top states:** Idle, Collect, Deliver.
  - **Idle:** `start` latches `n = min(bytes,4)`, clears the assembly register and count, and enters Collect. If `n = 0`, it goes straight to Deliver. Receiver strobes in Idle are discarded.
  - **Collect:**
    - On `rx_valid`, the byte at index k is written to `asm[8k+7:8k]` and k increments. When k reaches n, go to Deliver.
    - On `rx_err`, pulse `frame_err` and return to Idle; `word` is unchanged.
    - The gap counter resets on entering Collect and on each `rx_valid`. When it reaches `TIMEOUT_CLKS` (if nonzero), pulse `timeout` and return to Idle.
  - **Deliver:** `word <= asm` with unreceived bytes zero, pulse `valid`, go to Idle.
- `start` while busy is ignored.
- Error priority: if the timeout expires in the same cycle as `rx_valid`, the byte wins and the counter restarts.
- The receiver runs continuously and is independent of rx_top state; a byte in flight when arming completes is accepted.

## Timing
- `rx_valid`/`rx_err` assert 1 cycle after the stop-bit mid-sample.
- Collect→Deliver occurs on the cycle after the last `rx_valid`. `valid` and the new `word` appear 1 cycle after that, with `busy` low in the same cycle.
- With `n = 0`: `start` at cycle t gives `busy` at t+1 (Deliver) and `valid` at t+2 with `word` = 0.
- Synchronizer latency is 2 cycles; worst-case sample-point skew is ±1 clock plus sync delay.
- `rst_n` asserted mid-frame: everything returns to reset values immediately. After release, the receiver waits for the line high before it accepts a new falling edge.

## Structure
- A shared package `rx_pkg` holds the `rx_top` state enum and the receiver state enum (Idle, StartBit, DataBits, StopBit).
- One sub-module, `receiver`: clk, rst_n, RxD → `rx_byte`[8], `rx_valid`, `rx_err`.
- The word assembly register, byte index and gap counter all live in `rx_top`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and `TIMEOUT_CLKS` = 400.
- **Full word:** `start`, `bytes`=4; send 0x78, 0x56, 0x34, 0x12 → single `valid`, `word` = 0x12345678, `busy` low thereafter.
- **Partial word and clamp:**
  - `bytes`=2; send 0xAD, 0xDE → `word` = 0x0000DEAD.
  - `bytes`=7; send 4 bytes → `valid` after the 4th byte.
- **Zero length:** `bytes`=0 → `valid` exactly 2 cycles after `start`, `word` = 0, no line activity needed.
- **Frame error:** `bytes`=3; 2nd byte sent with its stop bit low → `frame_err` pulse, no `valid`, `word` keeps its previous value, `busy` low.
- **Timeout:** `bytes`=2; one byte, then the line idles for 500 clocks → `timeout` pulse once the gap counter reaches 400 clocks, Idle; a later byte produces no strobe.
- **Noise and reset:**
  - A 3-clock low glitch on `RxD` produces no `rx_valid`.
  - `rst_n` low mid-byte clears all outputs; a subsequent clean 1-byte transfer succeeds.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and helpers for the multi-byte UART receive front end.
package rx_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LEN_W     = 3;
    localparam int unsigned MAX_BYTES = 4;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_COLLECT,
        TOP_DELIVER
    } top_state_t;

    typedef enum logic [1:0] {
        RCV_IDLE,
        RCV_START,
        RCV_DATA,
        RCV_STOP
    } rcv_state_t;

    // Requested lengths above one full word collapse to a full word.
    function automatic logic [LEN_W-1:0] clamp_bytes(input logic [LEN_W-1:0] b);
        return (b > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : b;
    endfunction

endpackage

// File: rtl/rx_if.sv
// Control/result bundle between the word receiver and its consumer.
interface rx_if;
    logic                         start;
    logic [rx_pkg::LEN_W-1:0]     bytes;
    logic                         busy;
    logic [rx_pkg::WORD_W-1:0]    word;
    logic                         valid;
    logic                         frame_err;
    logic                         timeout;

    modport master (
        output start, bytes,
        input  busy, word, valid, frame_err, timeout
    );

    modport slave (
        input  start, bytes,
        output busy, word, valid, frame_err, timeout
    );
endinterface

// File: rtl/rx_receiver.sv
// Bit-level UART receiver: 8N1, mid-bit sampling, strobed byte output.
module receiver
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RxD,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              rx_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]        sync_q;
    logic              prev_q;
    logic              rx_s;
    rcv_state_t        state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [2:0]        bit_q, bit_n;
    logic [BYTE_W-1:0] shift_q, shift_n;
    logic [BYTE_W-1:0] byte_n;
    logic              valid_n, err_n;

    assign rx_s = sync_q[1];

    // Synchronizer resets low so a falling edge is only seen after the line has been high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], RxD};
            prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RCV_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            shift_q  <= shift_n;
            rx_byte  <= byte_n;
            rx_valid <= valid_n;
            rx_err   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        byte_n  = rx_byte;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            RCV_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_n = RCV_START;
                    cnt_n   = '0;
                end
            end
            RCV_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? RCV_IDLE : RCV_DATA;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RCV_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift_q[BYTE_W-1:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_n = RCV_STOP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RCV_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n   = '0;
                    byte_n  = shift_q;
                    valid_n = rx_s;
                    err_n   = !rx_s;
                    state_n = RCV_IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = RCV_IDLE;
        endcase
    end

endmodule

// File: rtl/rx_top.sv
// Word receiver: collects 0-4 UART bytes LSB-first into a 32-bit word with error/timeout abort.
module rx_top
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_CLKS = 86800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RxD,
    rx_if.slave  bus
);

    localparam int unsigned GAP_W = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid, rx_err;

    receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rcv (
        .clk      (clk),
        .rst_n    (rst_n),
        .RxD      (RxD),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    top_state_t        state_q, state_n;
    logic [LEN_W-1:0]  n_q, n_n;
    logic [LEN_W-1:0]  k_q, k_n, k_inc;
    logic [WORD_W-1:0] asm_q, asm_n;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic [WORD_W-1:0] word_q, word_n;
    logic              valid_q, valid_n;
    logic              ferr_q, ferr_n;
    logic              tmo_q, tmo_n;
    logic              busy_q, busy_n;

    assign k_inc = k_q + LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TOP_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            asm_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            n_q     <= n_n;
            k_q     <= k_n;
            asm_q   <= asm_n;
            gap_q   <= gap_n;
            word_q  <= word_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            tmo_q   <= tmo_n;
            busy_q  <= busy_n;
        end
    end

    // A received byte takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_n = state_q;
        n_n     = n_q;
        k_n     = k_q;
        asm_n   = asm_q;
        gap_n   = gap_q;
        word_n  = word_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        tmo_n   = 1'b0;
        case (state_q)
            TOP_IDLE: begin
                if (bus.start) begin
                    n_n     = clamp_bytes(bus.bytes);
                    k_n     = '0;
                    asm_n   = '0;
                    gap_n   = '0;
                    state_n = (clamp_bytes(bus.bytes) == '0) ? TOP_DELIVER : TOP_COLLECT;
                end
            end
            TOP_COLLECT: begin
                if (rx_valid) begin
                    asm_n[{k_q[1:0], 3'b000} +: BYTE_W] = rx_byte;
                    k_n   = k_inc;
                    gap_n = '0;
                    if (k_inc == n_q) state_n = TOP_DELIVER;
                end else if (rx_err) begin
                    ferr_n  = 1'b1;
                    state_n = TOP_IDLE;
                end else if ((TIMEOUT_CLKS != 0) && (gap_q == GAP_LAST)) begin
                    tmo_n   = 1'b1;
                    state_n = TOP_IDLE;
                end else begin
                    gap_n = gap_q + GAP_W'(1);
                end
            end
            TOP_DELIVER: begin
                word_n  = asm_q;
                valid_n = 1'b1;
                state_n = TOP_IDLE;
            end
            default: state_n = TOP_IDLE;
        endcase
        busy_n = (state_n != TOP_IDLE);
    end

    assign bus.busy      = busy_q;
    assign bus.word      = word_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_rx_top.sv
// Scoreboard bench for rx_top: directed UART frames, expected strobes queued and checked by a monitor.
module tb_rx_top;

    localparam int unsigned CPB = 16;
    localparam int unsigned TMO = 400;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FERR  = 2'd1;
    localparam logic [1:0] K_TMO   = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic RxD;

    rx_if bus ();

    rx_top #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RxD   (RxD),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rxv_cnt = 0;
    int   rxv_cyc = 0;
    int   tmo_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t       e;
        logic [1:0] kind;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (dut.u_rcv.rx_valid) begin
                    rxv_cnt++;
                    rxv_cyc = cyc;
                end
                if (bus.valid || bus.frame_err || bus.timeout) begin
                    if (bus.timeout) tmo_cyc = cyc;
                    case ({bus.timeout, bus.frame_err, bus.valid})
                        3'b001:  kind = K_VALID;
                        3'b010:  kind = K_FERR;
                        3'b100:  kind = K_TMO;
                        default: kind = 2'd3;
                    endcase
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 32'(kind), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_kind", 32'(kind), 32'(e.kind));
                        check("word", bus.word, e.word);
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_ok;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic arm(input logic [2:0] b);
        bus.start = 1'b1;
        bus.bytes = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bytes = 3'd0;
    endtask

    task automatic expect_strobe(input logic [1:0] k, input logic [31:0] w);
        exp_t e;
        e.kind = k;
        e.word = w;
        exp_q.push_back(e);
    endtask

    task automatic settle(input string name);
        repeat (40) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n0;
        rst_n     = 1'b0;
        RxD       = 1'b1;
        bus.start = 1'b0;
        bus.bytes = 3'd0;
        fork
            monitor();
        join_none
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_tmo", 32'(bus.timeout), 32'd0);
        check("rst_word", bus.word, 32'd0);

        // Full word; a start pulse mid-collection must be ignored.
        expect_strobe(K_VALID, 32'h1234_5678);
        arm(3'd4);
        check("full_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h78, 1'b1);
        arm(3'd0);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        settle("full_pending");
        check("full_busy_after", 32'(bus.busy), 32'd0);

        expect_strobe(K_VALID, 32'h0000_DEAD);
        arm(3'd2);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        settle("partial_pending");

        // Zero length: busy one cycle after start, valid the cycle after.
        expect_strobe(K_VALID, 32'h0);
        bus.start = 1'b1;
        bus.bytes = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_busy_t1", 32'(bus.busy), 32'd1);
        check("zero_valid_t1", 32'(bus.valid), 32'd0);
        @(negedge clk);
        check("zero_valid_t2", 32'(bus.valid), 32'd1);
        check("zero_word_t2", bus.word, 32'd0);
        check("zero_busy_t2", 32'(bus.busy), 32'd0);
        settle("zero_pending");

        // bytes=7 clamps to 4: no delivery after three bytes.
        expect_strobe(K_VALID, 32'h0403_0201);
        arm(3'd7);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (20) @(negedge clk);
        check("clamp_busy_3", 32'(bus.busy), 32'd1);
        check("clamp_pending_3", 32'(exp_q.size()), 32'd1);
        send_byte(8'h04, 1'b1);
        settle("clamp_pending");

        expect_strobe(K_FERR, 32'h0403_0201);
        arm(3'd3);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        settle("ferr_pending");
        check("ferr_busy", 32'(bus.busy), 32'd0);
        check("ferr_word", bus.word, 32'h0403_0201);

        expect_strobe(K_TMO, 32'h0403_0201);
        arm(3'd2);
        send_byte(8'h5A, 1'b1);
        repeat (500) @(negedge clk);
        check("tmo_pending", 32'(exp_q.size()), 32'd0);
        check("tmo_gap_near_400", 32'((tmo_cyc - rxv_cyc) >= 399 && (tmo_cyc - rxv_cyc) <= 403), 32'd1);
        check("tmo_busy", 32'(bus.busy), 32'd0);
        send_byte(8'hC3, 1'b1);
        settle("tmo_late_byte");

        n0 = rxv_cnt;
        RxD = 1'b0;
        repeat (3) @(negedge clk);
        RxD = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_rx_valid", 32'(rxv_cnt), 32'(n0));

        // Reset in the middle of a frame, then a clean single-byte transfer.
        arm(3'd1);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat (CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_word", bus.word, 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        expect_strobe(K_VALID, 32'h0000_00A5);
        arm(3'd1);
        send_byte(8'hA5, 1'b1);
        settle("post_rst_pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
